// File: rtl/rx_frame_parser.sv
// rtl/rx_frame_parser.sv - sync/len/payload/xor-checksum frame parser with buffered payload drain
// Optional inter-byte timeout enabled by defining RX_FRAME_TIMEOUT_EN.
module rx_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 1560
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t     state_q;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic [7:0] xor_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       out_last_q;
  logic       frame_ok_q;
  logic       frame_err_q;
  logic [7:0] buf_q [MAX_LEN];

  logic       in_frame;
  logic       idx_last;
  logic [7:0] xor_d;
  logic [7:0] rd_data;
  logic       buf_we;
  logic       tmo_hit;

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign idx_last = (idx_q == len_q - 8'd1);
  assign xor_d    = xor_q ^ din;
  assign rd_data  = buf_q[idx_q[IW-1:0]];
  assign buf_we   = (state_q == S_PAYLOAD) && rx_done_tick;

`ifdef RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CLKS - 1));

  // A received byte always wins over expiry in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (!in_frame || rx_done_tick || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Payload storage carries no reset; stale bytes are never presented.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q[IW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_HUNT: begin
          if (rx_done_tick && din == SYNC_BYTE) begin
            state_q <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_done_tick) begin
            if (din == 8'd0 || din > MAX_LEN_B) begin
              frame_err_q <= 1'b1;
              state_q     <= S_HUNT;
            end else begin
              len_q   <= din;
              xor_q   <= din;
              idx_q   <= '0;
              state_q <= S_PAYLOAD;
            end
          end else if (tmo_hit) begin
            frame_err_q <= 1'b1;
            state_q     <= S_HUNT;
          end
        end
        S_PAYLOAD: begin
          if (rx_done_tick) begin
            xor_q <= xor_d;
            if (idx_last) begin
              idx_q   <= '0;
              state_q <= S_CHK;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end else if (tmo_hit) begin
            frame_err_q <= 1'b1;
            state_q     <= S_HUNT;
          end
        end
        S_CHK: begin
          if (rx_done_tick) begin
            idx_q <= '0;
            if (din == xor_q) begin
              frame_ok_q <= 1'b1;
              state_q    <= S_DRAIN;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_HUNT;
            end
          end else if (tmo_hit) begin
            frame_err_q <= 1'b1;
            state_q     <= S_HUNT;
          end
        end
        S_DRAIN: begin
          if (rx_done_tick) begin
            frame_err_q <= 1'b1;
          end
          // First pass loads byte 0; afterwards each accepted beat loads the next.
          if (!out_valid_q || out_ready) begin
            if (out_valid_q && out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= S_HUNT;
            end else begin
              out_data_q  <= rd_data;
              out_last_q  <= idx_last;
              out_valid_q <= 1'b1;
              idx_q       <= idx_q + 8'd1;
            end
          end
        end
        default: state_q <= S_HUNT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_rx_frame_parser.sv
// tb/tb_rx_frame_parser.sv - directed self-checking bench for rx_frame_parser
module tb_rx_frame_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  rx_frame_parser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_done_tick (rx_done_tick),
    .din          (din),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0, err_cnt = 0, both_cnt = 0, stall_viol = 0, valid_cnt = 0, err_cyc = 0;
  logic [8:0] cap_q [$];
  int         cap_cyc [$];
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] seq [$];

  always @(negedge clk) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (frame_ok && frame_err) both_cnt++;
    if (out_valid) valid_cnt++;
    if (pv && !pr && (!out_valid || out_data != pd || out_last != pl)) stall_viol++;
    if (out_valid && out_ready) begin
      cap_q.push_back({out_last, out_data});
      cap_cyc.push_back(cyc);
    end
    pv = out_valid;
    pr = out_ready;
    pd = out_data;
    pl = out_last;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    din = b;
    rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    din = 8'h00;
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int ok0, err0, val0, t0, bad;

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_frame_ok",  32'(frame_ok),  32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(2);

    // Three-byte valid frame, always ready
    out_ready = 1'b1;
    ok0 = ok_cnt; err0 = err_cnt; cap_q.delete(); cap_cyc.delete();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq();
    wait_cycles(10);
    check("f3_ok",    32'(ok_cnt - ok0),   32'd1);
    check("f3_err",   32'(err_cnt - err0), 32'd0);
    check("f3_count", 32'(cap_q.size()),   32'd3);
    check("f3_b0",    32'(cap_q[0]),       32'h011);
    check("f3_b1",    32'(cap_q[1]),       32'h022);
    check("f3_b2",    32'(cap_q[2]),       32'h133);
    check("f3_consec", 32'(cap_cyc[2] - cap_cyc[0]), 32'd2);
    check("f3_busy",  32'(busy),           32'd0);

    // Bad checksum: 02^10^20 = 32, not 00
    ok0 = ok_cnt; err0 = err_cnt; val0 = valid_cnt;
    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_seq();
    wait_cycles(5);
    check("bad_chk_err",   32'(err_cnt - err0),   32'd1);
    check("bad_chk_ok",    32'(ok_cnt - ok0),     32'd0);
    check("bad_chk_valid", 32'(valid_cnt - val0), 32'd0);
    check("bad_chk_busy",  32'(busy),             32'd0);

    // Ignored bytes, then illegal lengths
    err0 = err_cnt;
    seq = '{8'h00, 8'hFF};
    send_seq();
    wait_cycles(3);
    check("hunt_ignore_err", 32'(err_cnt - err0), 32'd0);
    check("hunt_busy",       32'(busy),           32'd0);
    err0 = err_cnt;
    seq = '{8'hA5, 8'h00};
    send_seq();
    wait_cycles(3);
    check("len0_err",  32'(err_cnt - err0), 32'd1);
    check("len0_busy", 32'(busy),           32'd0);
    err0 = err_cnt;
    seq = '{8'hA5, 8'h11};
    send_seq();
    wait_cycles(3);
    check("len17_err", 32'(err_cnt - err0), 32'd1);

    // LEN = MAX_LEN: payload 00..0F XORs to 00, so CHK = 10
    ok0 = ok_cnt; cap_q.delete(); cap_cyc.delete();
    seq = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) seq.push_back(8'(i));
    seq.push_back(8'h10);
    send_seq();
    wait_cycles(22);
    check("max_ok",    32'(ok_cnt - ok0),  32'd1);
    check("max_count", 32'(cap_q.size()),  32'd16);
    check("max_b0",    32'(cap_q[0]),      32'h000);
    check("max_b15",   32'(cap_q[15]),     32'h10F);

    // One-byte frame held under backpressure, extra byte dropped during drain
    out_ready = 1'b0;
    ok0 = ok_cnt; err0 = err_cnt; cap_q.delete(); cap_cyc.delete();
    seq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_seq();
    send_byte(8'h55);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === 8'h7E && out_last === 1'b1)) bad++;
    end
    check("hold_stable",  32'(bad),              32'd0);
    check("hold_ok",      32'(ok_cnt - ok0),     32'd1);
    check("drop_err",     32'(err_cnt - err0),   32'd1);
    check("hold_nocap",   32'(cap_q.size()),     32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_cycles(4);
    check("hold_count", 32'(cap_q.size()), 32'd1);
    check("hold_b0",    32'(cap_q[0]),     32'h17E);
    check("hold_valid", 32'(out_valid),    32'd0);
    check("hold_busy",  32'(busy),         32'd0);

`ifdef RX_FRAME_TIMEOUT_EN
    // Silence after a partial payload expires the frame
    err0 = err_cnt;
    seq = '{8'hA5, 8'h04, 8'h01};
    send_seq();
    t0 = cyc;
    for (int i = 0; i < 2000 && err_cnt == err0; i++) @(posedge clk);
    #1;
    wait_cycles(2);
    check("tmo_err",    32'(err_cnt - err0), 32'd1);
    check("tmo_cycles", 32'(err_cyc - t0),   32'd1560);
    check("tmo_busy",   32'(busy),           32'd0);
    ok0 = ok_cnt;
    seq = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD};
    send_seq();
    wait_cycles(8);
    check("tmo_next_ok", 32'(ok_cnt - ok0), 32'd1);
`else
    // Without the timeout the parser waits indefinitely mid-payload
    err0 = err_cnt;
    seq = '{8'hA5, 8'h04, 8'h01};
    send_seq();
    wait_cycles(2000);
    check("notmo_err",  32'(err_cnt - err0), 32'd0);
    check("notmo_busy", 32'(busy),           32'd1);
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
`endif

    // Reset mid-payload discards silently; next frame parses
    ok0 = ok_cnt; err0 = err_cnt; val0 = valid_cnt; cap_q.delete(); cap_cyc.delete();
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_seq();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(3);
    check("rst_mid_err",   32'(err_cnt - err0),   32'd0);
    check("rst_mid_ok",    32'(ok_cnt - ok0),     32'd0);
    check("rst_mid_valid", 32'(valid_cnt - val0), 32'd0);
    seq = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD};
    send_seq();
    wait_cycles(8);
    check("post_rst_ok",    32'(ok_cnt - ok0),  32'd1);
    check("post_rst_count", 32'(cap_q.size()),  32'd2);
    check("post_rst_b0",    32'(cap_q[0]),      32'h0AA);
    check("post_rst_b1",    32'(cap_q[1]),      32'h155);

    check("never_ok_and_err", 32'(both_cnt),   32'd0);
    check("stall_stable",     32'(stall_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
